ieee754_mult_sequencer: RTL and testbench

Control sequencer for the IEEE-754 single-precision multiplier datapath on the board. It turns the operator's push-button presses into byte-load strobes that fill operand A and operand B, eight bytes in total and MSB first. It then starts the multiplier, waits for its completion handshake with a timeout, and steps the 7-segment display through the result halves. It replaces the simple load/ready control unit and drives the datapath's operand registers, multiplier start and display mux.

---
 rtl/ieee754_mult_sequencer_if.sv | 27 ++
 rtl/ieee754_mult_sequencer.sv | 153 +++++++++++++++
 tb/tb_ieee754_mult_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ieee754_mult_sequencer_if.sv
// Handshake and display-control bundle between the sequencer and the
// multiplier datapath (operand byte loads, start/done, display mux).
interface ieee754_mult_sequencer_if #(
    parameter int unsigned PAGE_W = 1
);
    logic              mult_done;
    logic              load_en;
    logic [2:0]        load_idx;
    logic              mult_start;
    logic [PAGE_W-1:0] disp_page;
    logic              show_result;
    logic              busy;
    logic              err;
    logic [2:0]        state_o;

    modport master (
        input  mult_done,
        output load_en, load_idx, mult_start, disp_page,
               show_result, busy, err, state_o
    );

    modport slave (
        output mult_done,
        input  load_en, load_idx, mult_start, disp_page,
               show_result, busy, err, state_o
    );
endinterface

// File: rtl/ieee754_mult_sequencer.sv
// Push-button driven control sequencer for the single-precision multiplier:
// loads operand bytes MSB first, starts the multiply, waits for completion
// with a timeout and pages the result onto the 7-segment display.
module ieee754_mult_sequencer #(
    parameter int unsigned NBYTES  = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned NPAGES  = 2
) (
    input  logic i_clk,
    input  logic i_nreset,
    input  logic i_nenter,
    ieee754_mult_sequencer_if.master bus
);

    localparam int unsigned PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    localparam logic [2:0]        LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NPAGES - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_SHOW  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            r_state;
    logic [2:0]        r_byte;
    logic [WAIT_W-1:0] r_wait;
    logic [PAGE_W-1:0] r_page;
    logic              r_load_en;
    logic [2:0]        r_load_idx;
    logic              r_mult_start;
    logic              r_show;
    logic              r_busy;
    logic              r_err;

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_press;

    // Two-flop synchronizer plus previous-value flop; idle level is high.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_nenter;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // One event per falling edge of the synchronized button, however long it is held.
    assign w_press = ~r_sync2 & r_prev;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state      <= S_LOAD;
            r_byte       <= '0;
            r_wait       <= '0;
            r_page       <= '0;
            r_load_en    <= 1'b0;
            r_load_idx   <= '0;
            r_mult_start <= 1'b0;
            r_show       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_en    <= 1'b0;
            r_mult_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_press) begin
                        r_load_en  <= 1'b1;
                        r_load_idx <= r_byte;
                        if (r_byte == LAST_BYTE) begin
                            r_byte  <= '0;
                            r_state <= S_START;
                            r_busy  <= 1'b1;
                        end else begin
                            r_byte <= r_byte + 3'd1;
                        end
                    end
                end
                S_START: begin
                    // Start pulse follows the final load so the two never overlap.
                    r_mult_start <= 1'b1;
                    r_wait       <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (bus.mult_done) begin
                        r_state <= S_SHOW;
                        r_page  <= '0;
                        r_busy  <= 1'b0;
                        r_show  <= 1'b1;
                    end else if (r_wait == LAST_WAIT) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (w_press) begin
                        if (r_page == LAST_PAGE) begin
                            r_state <= S_LOAD;
                            r_page  <= '0;
                            r_byte  <= '0;
                            r_show  <= 1'b0;
                        end else begin
                            r_page <= r_page + PAGE_W'(1);
                        end
                    end
                end
                S_ERROR: begin
                    if (w_press) begin
                        r_state <= S_LOAD;
                        r_byte  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_byte  <= '0;
                    r_page  <= '0;
                    r_show  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_en     = r_load_en;
    assign bus.load_idx    = r_load_idx;
    assign bus.mult_start  = r_mult_start;
    assign bus.disp_page   = r_page;
    assign bus.show_result = r_show;
    assign bus.busy        = r_busy;
    assign bus.err         = r_err;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_ieee754_mult_sequencer.sv
// Directed bench for the multiplier control sequencer (TIMEOUT=16).
module tb_ieee754_mult_sequencer;

    localparam int unsigned NBYTES  = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NPAGES  = 2;

    logic clk;
    logic nreset;
    logic nenter;

    int n_checks;
    int n_errors;

    ieee754_mult_sequencer_if #(.PAGE_W(1)) bus ();

    ieee754_mult_sequencer #(
        .NBYTES (NBYTES),
        .TIMEOUT(TIMEOUT),
        .NPAGES (NPAGES)
    ) dut (
        .i_clk   (clk),
        .i_nreset(nreset),
        .i_nenter(nenter),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the button low; returns at the sample point right after the response edge.
    task automatic press_edge();
        nenter = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_early_load", 32'(bus.load_en), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic release_btn();
        nenter = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Load bytes first..last; for the final byte, returns at the sample point
    // of the first WAIT cycle (mult_start high).
    task automatic load_bytes(input int first, input int last);
        for (int b = first; b <= last; b++) begin
            press_edge();
            chk("load_en", 32'(bus.load_en), 32'd1);
            chk("load_idx", 32'(bus.load_idx), 32'(b));
            chk("load_state", 32'(bus.state_o), (b == NBYTES - 1) ? 32'd1 : 32'd0);
            chk("load_no_start", 32'(bus.mult_start), 32'd0);
            @(negedge clk);
            chk("load_width", 32'(bus.load_en), 32'd0);
            if (b == NBYTES - 1) begin
                chk("wait_state", 32'(bus.state_o), 32'd2);
                chk("mult_start", 32'(bus.mult_start), 32'd1);
                chk("busy", 32'(bus.busy), 32'd1);
                nenter = 1'b1;
            end else begin
                @(negedge clk);
                release_btn();
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load_en"}, 32'(bus.load_en), 32'd0);
        chk({tag, "_load_idx"}, 32'(bus.load_idx), 32'd0);
        chk({tag, "_start"}, 32'(bus.mult_start), 32'd0);
        chk({tag, "_page"}, 32'(bus.disp_page), 32'd0);
        chk({tag, "_show"}, 32'(bus.show_result), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_state"}, 32'(bus.state_o), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [2:0] idx;
        n_checks      = 0;
        n_errors      = 0;
        nreset        = 1'b0;
        nenter        = 1'b1;
        bus.mult_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        nreset = 1'b1;
        @(negedge clk);

        // Full operation with completion after 10 cycles, then page through.
        load_bytes(0, 7);
        @(negedge clk);
        chk("start_width", 32'(bus.mult_start), 32'd0);
        repeat (8) @(negedge clk);
        chk("still_wait", 32'(bus.state_o), 32'd2);
        bus.mult_done = 1'b1;
        @(negedge clk);
        bus.mult_done = 1'b0;
        chk("show_state", 32'(bus.state_o), 32'd3);
        chk("show_result", 32'(bus.show_result), 32'd1);
        chk("show_page0", 32'(bus.disp_page), 32'd0);
        chk("show_busy", 32'(bus.busy), 32'd0);
        press_edge();
        chk("show_page1", 32'(bus.disp_page), 32'd1);
        chk("show_state1", 32'(bus.state_o), 32'd3);
        release_btn();
        press_edge();
        chk("back_load", 32'(bus.state_o), 32'd0);
        chk("back_page", 32'(bus.disp_page), 32'd0);
        chk("back_show", 32'(bus.show_result), 32'd0);
        release_btn();

        // Timeout: no done, error exactly TIMEOUT cycles after entering WAIT.
        load_bytes(0, 7);
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk("to_no_err", 32'(bus.err), 32'd0);
            chk("to_wait", 32'(bus.state_o), 32'd2);
        end
        @(negedge clk);
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_state", 32'(bus.state_o), 32'd4);
        chk("to_busy", 32'(bus.busy), 32'd0);
        press_edge();
        chk("err_clear", 32'(bus.err), 32'd0);
        chk("err_load", 32'(bus.state_o), 32'd0);
        release_btn();

        // Long hold gives a single load.
        nenter = 1'b0;
        cnt    = 0;
        idx    = 3'd7;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.load_en) begin
                cnt++;
                idx = bus.load_idx;
            end
        end
        chk("hold_count", 32'(cnt), 32'd1);
        chk("hold_idx", 32'(idx), 32'd0);
        release_btn();

        // Done pulses outside WAIT are ignored.
        for (int i = 0; i < 3; i++) begin
            bus.mult_done = 1'b1;
            @(negedge clk);
            bus.mult_done = 1'b0;
            @(negedge clk);
            chk("done_ign_state", 32'(bus.state_o), 32'd0);
            chk("done_ign_start", 32'(bus.mult_start), 32'd0);
        end
        load_bytes(1, 7);

        // Press inside WAIT is ignored, then let it time out.
        press_edge();
        chk("wait_press_load", 32'(bus.load_en), 32'd0);
        chk("wait_press_state", 32'(bus.state_o), 32'd2);
        release_btn();
        repeat (7) @(negedge clk);
        chk("wait2_state", 32'(bus.state_o), 32'd2);
        @(negedge clk);
        chk("wait2_err", 32'(bus.state_o), 32'd4);
        press_edge();
        release_btn();

        // Reset mid-load abandons the partial operand.
        load_bytes(0, 4);
        nreset = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        nreset = 1'b1;
        @(negedge clk);

        // Done coincident with the final timeout cycle wins.
        load_bytes(0, 7);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("coin_wait", 32'(bus.state_o), 32'd2);
        bus.mult_done = 1'b1;
        @(negedge clk);
        bus.mult_done = 1'b0;
        chk("coin_state", 32'(bus.state_o), 32'd3);
        chk("coin_err", 32'(bus.err), 32'd0);
        chk("coin_show", 32'(bus.show_result), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
